// File: rtl/cog_point_transmitter.sv
// Turns per-figure CoG sums into fixed-point coordinates and streams them, together
// with line/frame markers, in event order over AXI4-Stream.
module cog_point_transmitter #(
   parameter int unsigned FRAC_BITS  = 4,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_aresetn,
   input  logic [29:0] i_sum_of_I_mult_coord,
   input  logic [22:0] i_sum_of_I,
   input  logic [10:0] i_start_point,
   input  logic        i_point_valid,
   input  logic        i_end_of_line,
   input  logic        i_end_of_frame,
   input  logic        i_new_frame,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        o_overflow,
   output logic        o_busy
);

   localparam int unsigned DIV_CYCLES = 30 + FRAC_BITS;
   localparam int unsigned QW         = 30 + FRAC_BITS;
   localparam int unsigned SW         = QW + 1;
   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam int unsigned CW         = $clog2(DIV_CYCLES);
   localparam int unsigned EW         = 68;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SOF, S_DIV, S_PUT_PT, S_PUT_EOL, S_PUT_EOF
   } state_t;

   state_t state_q, state_d;

   // ---------------- event FIFO ----------------
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, fifo_cnt;
   logic          fifo_empty, fifo_full, any_strobe, fifo_push;
   logic [EW-1:0] fifo_head;

   assign fifo_cnt   = wr_ptr - rd_ptr;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
   assign any_strobe = i_point_valid | i_end_of_line | i_end_of_frame | i_new_frame;
   assign fifo_push  = any_strobe & ~fifo_full;
   assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_sys_clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr[AW-1:0]] <= {i_new_frame, i_point_valid, i_end_of_line, i_end_of_frame,
                                      i_sum_of_I_mult_coord, i_sum_of_I, i_start_point};
   end

   // The head slot stays occupied until the FSM has finished every flag of its entry,
   // so the in-flight event counts against FIFO capacity.
   logic capture, release_entry;

   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (fifo_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (release_entry)
            rd_ptr <= rd_ptr + 1'b1;
         if (any_strobe && fifo_full)
            o_overflow <= 1'b1;
      end
   end

   // ---------------- working entry / divider ----------------
   logic          e_sof, e_pt, e_eol, e_eof;
   logic [29:0]   e_num;
   logic [22:0]   e_den;
   logic [10:0]   e_start;
   logic [22:0]   div_rem, div_rem_nx;
   logic [QW-1:0] div_q, div_q_nx, quot;
   logic [CW-1:0] div_cnt;
   logic [23:0]   div_trial;
   logic          div_ge, div_last;
   logic [SW-1:0] coord_sum;
   logic [15:0]   coord;
   logic [10:0]   line_idx;
   logic          sof_pending;

   always_comb begin
      div_trial  = {div_rem, div_q[QW-1]};
      div_ge     = (div_trial >= {1'b0, e_den});
      div_rem_nx = div_ge ? 23'(div_trial - {1'b0, e_den}) : div_trial[22:0];
      div_q_nx   = {div_q[QW-2:0], div_ge};
      div_last   = (div_cnt == CW'(DIV_CYCLES - 1)) || (e_den == '0);
      quot       = (e_den == '0) ? '0 : div_q_nx;
      coord_sum  = SW'({e_start, {FRAC_BITS{1'b0}}}) + SW'(quot);
      coord      = (coord_sum > SW'(16'hFFFF)) ? 16'hFFFF : coord_sum[15:0];
   end

   // ---------------- control FSM ----------------
   logic go_sof, do_sof, div_init, ld_pt, ld_eol, ld_eof, hs;

   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      capture       = 1'b0;
      release_entry = 1'b0;
      go_sof        = 1'b0;
      do_sof        = 1'b0;
      div_init      = 1'b0;
      ld_pt         = 1'b0;
      ld_eol        = 1'b0;
      ld_eof        = 1'b0;
      hs            = 1'b0;
      m_axis_tvalid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               capture = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (e_sof) begin
               go_sof  = 1'b1;
               state_d = S_SOF;
            end else if (e_pt) begin
               div_init = 1'b1;
               state_d  = S_DIV;
            end else if (e_eol) begin
               ld_eol  = 1'b1;
               state_d = S_PUT_EOL;
            end else if (e_eof) begin
               ld_eof  = 1'b1;
               state_d = S_PUT_EOF;
            end else begin
               release_entry = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_SOF: begin
            do_sof  = 1'b1;
            state_d = S_LOAD;
         end
         S_DIV: begin
            if (div_last) begin
               ld_pt   = 1'b1;
               state_d = S_PUT_PT;
            end
         end
         S_PUT_PT, S_PUT_EOL, S_PUT_EOF: begin
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) begin
               hs      = 1'b1;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_busy = ~fifo_empty | (state_q != S_IDLE);

   // ---------------- datapath ----------------
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         e_sof        <= 1'b0;
         e_pt         <= 1'b0;
         e_eol        <= 1'b0;
         e_eof        <= 1'b0;
         e_num        <= '0;
         e_den        <= '0;
         e_start      <= '0;
         div_rem      <= '0;
         div_q        <= '0;
         div_cnt      <= '0;
         line_idx     <= '0;
         sof_pending  <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
         m_axis_tuser <= 1'b0;
      end else begin
         if (capture)
            {e_sof, e_pt, e_eol, e_eof, e_num, e_den, e_start} <= fifo_head;
         if (go_sof)
            e_sof <= 1'b0;
         if (div_init) begin
            e_pt    <= 1'b0;
            div_rem <= '0;
            div_q   <= {e_num, {FRAC_BITS{1'b0}}};
            div_cnt <= '0;
         end
         if (state_q == S_DIV) begin
            div_rem <= div_rem_nx;
            div_q   <= div_q_nx;
            div_cnt <= div_cnt + 1'b1;
         end
         if (do_sof) begin
            line_idx    <= '0;
            sof_pending <= 1'b1;
         end
         if (ld_pt) begin
            m_axis_tdata <= {2'b00, 3'b000, line_idx, coord};
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= sof_pending;
         end
         if (ld_eol) begin
            e_eol        <= 1'b0;
            m_axis_tdata <= {2'b01, 3'b000, line_idx, 16'h0000};
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= sof_pending;
         end
         if (ld_eof) begin
            e_eof        <= 1'b0;
            m_axis_tdata <= {2'b10, 3'b000, line_idx, 16'h0000};
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= sof_pending;
         end
         if (hs) begin
            sof_pending <= 1'b0;
            if (state_q == S_PUT_EOL)
               line_idx <= line_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cog_point_transmitter.sv
// Scoreboard bench for cog_point_transmitter: expected words are queued as events
// are strobed and compared as the stream delivers them.
module tb_cog_point_transmitter;

   localparam int unsigned FRAC = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [29:0] num = '0;
   logic [22:0] den = '0;
   logic [10:0] start = '0;
   logic        pt = 1'b0, eol = 1'b0, eof = 1'b0, sof = 1'b0;
   logic [31:0] tdata;
   logic        tvalid, tlast, tuser;
   logic        tready = 1'b1;
   logic        overflow, busy;

   cog_point_transmitter #(.FRAC_BITS(4), .FIFO_DEPTH(16)) dut (
      .i_sys_clk             (clk),
      .i_sys_aresetn         (rstn),
      .i_sum_of_I_mult_coord (num),
      .i_sum_of_I            (den),
      .i_start_point         (start),
      .i_point_valid         (pt),
      .i_end_of_line         (eol),
      .i_end_of_frame        (eof),
      .i_new_frame           (sof),
      .m_axis_tdata          (tdata),
      .m_axis_tvalid         (tvalid),
      .m_axis_tready         (tready),
      .m_axis_tlast          (tlast),
      .m_axis_tuser          (tuser),
      .o_overflow            (overflow),
      .o_busy                (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [33:0] sb[$];
   logic [10:0] m_line = '0;
   bit          m_sof  = 1'b0;

   function automatic logic [15:0] ref_coord(input logic [29:0] n, input logic [22:0] d,
                                             input logic [10:0] s);
      longint unsigned q, c;
      q = (d == 0) ? 0 : ((longint'(n) << FRAC) / longint'(d));
      c = (longint'(s) << FRAC) + q;
      return (c > 64'hFFFF) ? 16'hFFFF : c[15:0];
   endfunction

   function automatic void push_word(input logic [1:0] ty, input logic [15:0] c, input bit last);
      sb.push_back({last, m_sof, ty, 3'b000, m_line, c});
      m_sof = 1'b0;
   endfunction

   function automatic void model_event(input bit s, input bit p, input bit l, input bit f,
                                       input logic [29:0] n, input logic [22:0] d,
                                       input logic [10:0] st);
      if (s) begin
         m_line = '0;
         m_sof  = 1'b1;
      end
      if (p) push_word(2'b00, ref_coord(n, d, st), 1'b0);
      if (l) begin
         push_word(2'b01, 16'h0000, 1'b0);
         m_line = m_line + 1'b1;
      end
      if (f) push_word(2'b10, 16'h0000, 1'b1);
   endfunction

   // ---------------- output monitor ----------------
   logic [33:0] held;
   bit          stalled = 1'b0;
   always @(negedge clk) begin
      if (!rstn) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check_val("valid_hold", 64'(tvalid), 64'd1);
            check_val("stable", 64'({tlast, tuser, tdata}), 64'(held));
         end
         if (tvalid && tready) begin
            if (sb.size() == 0)
               check_val("sb_underflow", 64'(sb.size()), 64'd1);
            else
               check_val("word", 64'({tlast, tuser, tdata}), 64'(sb.pop_front()));
         end
         stalled = tvalid && !tready;
         held    = {tlast, tuser, tdata};
      end
   end

   // ---------------- stimulus helpers (main thread sits at posedge+1) ----------------
   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ev(input bit s, input bit p, input bit l, input bit f, input logic [29:0] n,
                     input logic [22:0] d, input logic [10:0] st, input bit expect_it);
      sof = s; pt = p; eol = l; eof = f;
      num = n; den = d; start = st;
      if (expect_it) model_event(s, p, l, f, n, d, st);
      idle(1);
      sof = 1'b0; pt = 1'b0; eol = 1'b0; eof = 1'b0;
   endtask

   task automatic wait_valid(input int unsigned t0, input int unsigned exp_lat, input string tag);
      int unsigned n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (tvalid) break;
         n++;
      end
      check_val(tag, 64'(cyc - t0), 64'(exp_lat));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int unsigned budget, input bit rnd);
      int unsigned n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         if (rnd) tready = 1'($urandom_range(0, 1));
         idle(1);
         n++;
      end
      if (rnd) tready = 1'b1;
      check_val("drain", 64'({sb.size() != 0, busy}), 64'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val(tag, 64'({tdata, tvalid, tlast, tuser, overflow, busy}), 64'd0);
   endtask

   task automatic frame_sequence();
      int unsigned t0;
      ev(1, 0, 0, 0, '0, '0, '0, 1);
      idle(8);
      t0 = cyc;
      ev(0, 1, 0, 0, 30'd1600, 23'd100, 11'd20, 1);
      wait_valid(t0, 37, "latency_point");
      ev(0, 0, 1, 0, '0, '0, '0, 1);
      ev(0, 0, 0, 1, '0, '0, '0, 1);
      drain(400, 0);
   endtask

   initial begin
      int unsigned t0;
      idle(2);
      check_outputs_zero("reset_outputs");
      rstn = 1'b1;
      idle(2);
      check_outputs_zero("after_release");

      // SOF / point / EOL / EOF: 0x0000_0240 (tuser), 0x4000_0000, 0x8001_0000 (tlast)
      frame_sequence();

      // 7.5 in Q12.4
      ev(0, 1, 0, 0, 30'd250, 23'd100, 11'd5, 1);
      drain(200, 0);

      // den = 0 takes one divide cycle
      t0 = cyc;
      ev(0, 1, 0, 0, 30'd999, 23'd0, 11'd3, 1);
      wait_valid(t0, 4, "latency_den0");
      drain(200, 0);

      // merged point+EOL, then a point on the next line
      ev(0, 1, 1, 0, 30'd12345, 23'd77, 11'd100, 1);
      ev(0, 1, 0, 0, 30'd500, 23'd3, 11'd1, 1);
      drain(400, 0);

      // saturation boundaries near 16'hFFFF
      ev(0, 1, 0, 0, 30'd2000, 23'd1, 11'd2047, 1);
      ev(0, 1, 0, 0, 30'd2300, 23'd1, 11'd2047, 1);
      ev(0, 1, 0, 0, 30'h3FFF_FFFF, 23'd1, 11'd0, 1);
      ev(0, 1, 0, 0, 30'h3FFF_FFFF, 23'h7F_FFFF, 11'd0, 1);
      drain(600, 0);

      // random points and markers under random backpressure
      for (int i = 0; i < 8; i++) begin
         ev(1'(i == 0), 1, 1'($urandom_range(0, 1)), 1'(i == 7),
            30'($urandom), 23'($urandom_range(1, 8388607)), 11'($urandom_range(0, 2047)), 1);
         idle($urandom_range(0, 5));
      end
      drain(2000, 1);

      // overflow: 20 strobes with the sink stalled, only 16 survive
      check_val("no_overflow_yet", 64'(overflow), 64'd0);
      tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ev(0, 1, 0, 0, 30'(1000 + 37 * i), 23'(7 + i), 11'(i), 1'(i < 16));
         idle(2);
      end
      check_val("overflow", 64'(overflow), 64'd1);
      check_val("stall_valid", 64'(tvalid), 64'd1);
      tready = 1'b1;
      drain(1200, 0);
      check_val("overflow_sticky", 64'(overflow), 64'd1);

      // reset in the middle of a division
      ev(0, 1, 0, 0, 30'd777, 23'd11, 11'd9, 0);
      idle(10);
      #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero("reset_in_div");
      idle(2);
      rstn = 1'b1;
      idle(2);

      // reset while a word is presented and stalled
      tready = 1'b0;
      ev(0, 1, 0, 0, 30'd777, 23'd11, 11'd9, 0);
      idle(45);
      check_val("stalled_word", 64'(tvalid), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero("reset_in_put");
      m_line = '0;
      m_sof  = 1'b0;
      sb.delete();
      tready = 1'b1;
      idle(2);
      rstn = 1'b1;
      idle(2);

      // behaves as from power-up
      frame_sequence();

      check_val("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
